fetch_decode_queue: RTL and testbench

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

---
 rtl/fetch_decode_queue.sv | 106 ++++++++++
 tb/tb_fetch_decode_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, inst} entries with flush.
// Optional same-cycle empty-queue bypass when FDQ_BYPASS_EN is defined.
module fetch_decode_queue #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       if_valid,
   output logic                       if_ready,
   input  logic [PC_W-1:0]            if_pc,
   input  logic [INST_W-1:0]          if_inst,
   output logic                       id_valid,
   input  logic                       id_ready,
   output logic [PC_W-1:0]            id_pc,
   output logic [INST_W-1:0]          id_inst,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PC_W-1:0]   r_pc_mem   [DEPTH];
   logic [INST_W-1:0] r_inst_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_wr_mem;
   logic w_rd_mem;

   assign w_empty  = (r_count == '0);
   assign if_ready = (r_count != FULL_CNT);
   assign count    = r_count;

   assign w_push = if_valid && if_ready && !flush;
   assign w_pop  = id_valid && id_ready && !flush;

`ifdef FDQ_BYPASS_EN
   logic w_bypass;
   assign w_bypass = w_empty && if_valid && !flush;

   // A bypassed entry consumed this cycle never touches storage.
   assign w_wr_mem = w_push && !(w_bypass && id_ready);
   assign w_rd_mem = w_pop && !w_empty;

   always_comb begin
      id_valid = 1'b0;
      id_pc    = '0;
      id_inst  = '0;
      if (!w_empty) begin
         id_valid = 1'b1;
         id_pc    = r_pc_mem[r_rd_ptr];
         id_inst  = r_inst_mem[r_rd_ptr];
      end else if (w_bypass) begin
         id_valid = 1'b1;
         id_pc    = if_pc;
         id_inst  = if_inst;
      end
   end
`else
   assign w_wr_mem = w_push;
   assign w_rd_mem = w_pop;

   always_comb begin
      id_valid = !w_empty;
      id_pc    = '0;
      id_inst  = '0;
      if (!w_empty) begin
         id_pc   = r_pc_mem[r_rd_ptr];
         id_inst = r_inst_mem[r_rd_ptr];
      end
   end
`endif

   // Storage carries no reset; occupancy alone qualifies its contents.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_mem) begin
         r_pc_mem[r_wr_ptr]   <= if_pc;
         r_inst_mem[r_wr_ptr] <= if_inst;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_mem) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_rd_mem) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_wr_mem, w_rd_mem})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (DEPTH=4).
// Expectations follow FDQ_BYPASS_EN where the bypass changes visible timing.
module tb_fetch_decode_queue;

   localparam int PC_W   = 32;
   localparam int INST_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              if_valid;
   logic              if_ready;
   logic [PC_W-1:0]   if_pc;
   logic [INST_W-1:0] if_inst;
   logic              id_valid;
   logic              id_ready;
   logic [PC_W-1:0]   id_pc;
   logic [INST_W-1:0] id_inst;
   logic [CNT_W-1:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_decode_queue #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .if_valid (if_valid),
      .if_ready (if_ready),
      .if_pc    (if_pc),
      .if_inst  (if_inst),
      .id_valid (id_valid),
      .id_ready (id_ready),
      .id_pc    (id_pc),
      .id_inst  (id_inst),
      .count    (count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst);
      if_valid = v;
      if_pc    = pc;
      if_inst  = inst;
   endtask

   initial begin
      int nxt;
      int rd_idx;
      int cyc;

      // Reset held two cycles with fetch offering
      rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
      offer(1'b1, 32'h99, 32'h99);
      tick();
      tick();
      rst = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_id_pc", 64'(id_pc), 64'd0);
      chk("rst_id_inst", 64'(id_inst), 64'd0);
      chk("rst_if_ready", 64'(if_ready), 64'd1);

      // Fill with decode stalled
      for (int i = 0; i < 4; i++) begin
         offer(1'b1, 32'(i * 4), 32'(32'h1000 + i));
         #1;
         chk("fill_if_ready", 64'(if_ready), 64'd1);
         if (i == 0) begin
`ifdef FDQ_BYPASS_EN
            chk("fill_first_id_valid", 64'(id_valid), 64'd1);
`else
            chk("fill_first_id_valid", 64'(id_valid), 64'd0);
`endif
         end
         tick();
      end
      offer(1'b1, 32'h10, 32'h1004);
      #1;
      chk("full_count", 64'(count), 64'd4);
      chk("full_if_ready", 64'(if_ready), 64'd0);
      chk("full_id_pc", 64'(id_pc), 64'h00);
      chk("full_id_inst", 64'(id_inst), 64'h1000);
      tick();
      #1;
      chk("full_reject_count", 64'(count), 64'd4);
      chk("stall_hold_pc", 64'(id_pc), 64'h00);

      // Drain while pushing 0x10..0x1C; pointers wrap twice
      id_ready = 1'b1;
      nxt = 4;
      rd_idx = 0;
      cyc = 0;
      while (rd_idx < 8 && cyc < 30) begin
         if (nxt < 8) offer(1'b1, 32'(nxt * 4), 32'(32'h1000 + nxt));
         else offer(1'b0, 32'h0, 32'h0);
         #1;
         if (if_valid && if_ready) nxt++;
         if (id_valid) begin
            chk("drain_pc", 64'(id_pc), 64'(rd_idx * 4));
            chk("drain_inst", 64'(id_inst), 64'(32'h1000 + rd_idx));
            rd_idx++;
         end
         tick();
         cyc++;
      end
      chk("drain_all_seen", 64'(rd_idx), 64'd8);
      offer(1'b0, 32'h0, 32'h0);
      #1;
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_id_valid", 64'(id_valid), 64'd0);

      // Flush at count 3 drops held and incoming entries
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         offer(1'b1, 32'(32'h20 + i * 4), 32'(32'h2000 + i));
         tick();
      end
      offer(1'b0, 32'h0, 32'h0);
      #1;
      chk("pre_flush_count", 64'(count), 64'd3);
      flush = 1'b1;
      offer(1'b1, 32'h40, 32'h40);
      tick();
      flush = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      id_ready = 1'b1;
      #1;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_id_valid", 64'(id_valid), 64'd0);
      chk("flush_id_inst", 64'(id_inst), 64'd0);
      chk("flush_id_pc", 64'(id_pc), 64'd0);
      tick();
      #1;
      chk("flush_no_0x40", 64'(id_valid), 64'd0);

      // Full with simultaneous pop: push rejected, accepted next cycle
      id_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         offer(1'b1, 32'(32'h60 + i * 4), 32'(32'h6000 + i));
         tick();
      end
      id_ready = 1'b1;
      offer(1'b1, 32'h50, 32'h5000);
      #1;
      chk("fp_count4", 64'(count), 64'd4);
      chk("fp_if_ready_low", 64'(if_ready), 64'd0);
      chk("fp_head", 64'(id_pc), 64'h60);
      tick();
      id_ready = 1'b0;
      #1;
      chk("fp_count3", 64'(count), 64'd3);
      chk("fp_if_ready_high", 64'(if_ready), 64'd1);
      chk("fp_head2", 64'(id_pc), 64'h64);
      tick();
      offer(1'b0, 32'h0, 32'h0);
      #1;
      chk("fp_count_back4", 64'(count), 64'd4);
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("fp_order", 64'(id_pc), (i < 3) ? 64'(32'h64 + i * 4) : 64'h50);
         tick();
      end
      #1;
      chk("fp_empty", 64'(count), 64'd0);

      // Empty queue: bypass or one-cycle latency
      offer(1'b1, 32'h80, 32'h00000013);
      #1;
`ifdef FDQ_BYPASS_EN
      chk("byp_id_valid", 64'(id_valid), 64'd1);
      chk("byp_id_pc", 64'(id_pc), 64'h80);
      chk("byp_id_inst", 64'(id_inst), 64'h13);
      tick();
      offer(1'b0, 32'h0, 32'h0);
      #1;
      chk("byp_count", 64'(count), 64'd0);
      chk("byp_consumed", 64'(id_valid), 64'd0);
`else
      chk("nobyp_id_valid0", 64'(id_valid), 64'd0);
      chk("nobyp_id_pc0", 64'(id_pc), 64'd0);
      tick();
      offer(1'b0, 32'h0, 32'h0);
      #1;
      chk("nobyp_id_valid1", 64'(id_valid), 64'd1);
      chk("nobyp_id_pc1", 64'(id_pc), 64'h80);
      chk("nobyp_id_inst1", 64'(id_inst), 64'h13);
      chk("nobyp_count1", 64'(count), 64'd1);
      tick();
      #1;
      chk("nobyp_count_after", 64'(count), 64'd0);
`endif

      // Mid-stream reset overrides flush and handshakes
      id_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         offer(1'b1, 32'(32'hA0 + i * 4), 32'(32'hA000 + i));
         tick();
      end
      rst = 1'b1;
      flush = 1'b1;
      id_ready = 1'b1;
      offer(1'b1, 32'hB0, 32'hB000);
      tick();
      rst = 1'b0;
      flush = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      #1;
      chk("mrst_count", 64'(count), 64'd0);
      chk("mrst_id_valid", 64'(id_valid), 64'd0);
      chk("mrst_if_ready", 64'(if_ready), 64'd1);
      chk("mrst_id_pc", 64'(id_pc), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
